// File: rtl/rr_pkt_mux_pkg.sv
// rr_pkt_mux shared definitions: FSM state encoding and default parameters.
// Included by the mux top and its output register stage.
package rr_pkt_mux_pkg;

    localparam int DEF_NREQ          = 2;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_MAX_PKT_BEATS = 256;

    // Stream lock FSM: wait for grant, pass a packet, let the arbiter update
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pkt_mux_oreg.sv
// rr_pkt_mux output stage: one valid/ready register carrying
// {last, src, data}; it loads whenever it is empty or being drained.
module rr_pkt_mux_oreg
    import rr_pkt_mux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_load,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_load  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Take a new beat when free; payload frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/rr_pkt_mux.sv
// rr_pkt_mux: packet-locked N:1 stream mux driven by an external arbiter.
// Optional statistics (pktCnt/truncCnt) when RR_PKT_MUX_STATS_EN is defined.
module rr_pkt_mux
    import rr_pkt_mux_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            inValid,
    input  logic [NREQ*DATA_WIDTH-1:0] inData,
    input  logic [NREQ-1:0]            inLast,
    output logic [NREQ-1:0]            inReady,
    output logic [NREQ-1:0]            reqBus,
    input  logic [NREQ-1:0]            grantBus,
    output logic                       reqArb,
    output logic                       outValid,
    output logic [DATA_WIDTH-1:0]      outData,
    output logic                       outLast,
    output logic [$clog2(NREQ)-1:0]    outSrc,
    input  logic                       outReady,
    output logic                       truncErr
`ifdef RR_PKT_MUX_STATS_EN
    ,
    output logic [31:0]                pktCnt,
    output logic [15:0]                truncCnt
`endif
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam int PW = DATA_WIDTH + 1 + SW;

    state_t          r_state;
    logic [SW-1:0]   r_sel;
    logic [CW-1:0]   r_cnt;
    logic            r_reqArb;

    logic [SW-1:0]   w_gIdx;
    logic            w_gHit;
    logic            w_load;
    logic            w_acc;
    logic            w_atMax;
    logic            w_selLast;
    logic            w_end;
    logic            w_trunc;
    logic [DATA_WIDTH-1:0] w_selData;
    logic [PW-1:0]   w_pIn;
    logic [PW-1:0]   w_pOut;

    assign reqBus   = inValid;
    assign reqArb   = r_reqArb;
    assign truncErr = w_trunc;

    // Granted index from the one-hot grant
    always_comb begin
        w_gIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantBus[i]) begin
                w_gIdx = w_gIdx | SW'(i);
            end
        end
    end

    assign w_gHit    = |(grantBus & inValid);
    assign w_selData = inData[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_selLast = inLast[r_sel];

    // Only the locked stream may be accepted, and only when the
    // output register can take the beat this cycle
    always_comb begin
        inReady = '0;
        if (r_state == PASS) begin
            inReady[r_sel] = w_load;
        end
    end

    assign w_acc   = (r_state == PASS) && inValid[r_sel] && w_load;
    assign w_atMax = (r_cnt == CW'(MAX_PKT_BEATS - 1));
    assign w_end   = w_acc && (w_selLast || w_atMax);
    assign w_trunc = w_acc && !w_selLast && w_atMax;

    // A forced end at the beat limit is marked as last downstream
    assign w_pIn = {(w_selLast || w_atMax), r_sel, w_selData};

    rr_pkt_mux_oreg #(
        .W (PW)
    ) u_oreg (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc),
        .i_data  (w_pIn),
        .i_ready (outReady),
        .o_load  (w_load),
        .o_valid (outValid),
        .o_data  (w_pOut)
    );

    assign {outLast, outSrc, outData} = w_pOut;

    // Lock FSM: packet end is decided at acceptance, not at output,
    // so a downstream stall never delays the re-arbitrate pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_reqArb <= 1'b0;
        end else begin
            r_reqArb <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|grantBus && w_gHit) begin
                        r_sel   <= w_gIdx;
                        r_state <= PASS;
                    end
                end
                PASS: begin
                    if (w_end) begin
                        r_cnt    <= '0;
                        r_reqArb <= 1'b1;
                        r_state  <= SETTLE;
                    end else if (w_acc) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SETTLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef RR_PKT_MUX_STATS_EN
    logic [31:0] r_pktCnt;
    logic [15:0] r_truncCnt;

    assign pktCnt   = r_pktCnt;
    assign truncCnt = r_truncCnt;

    // Packet ends wrap; truncations saturate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pktCnt   <= '0;
            r_truncCnt <= '0;
        end else begin
            if (w_end) begin
                r_pktCnt <= r_pktCnt + 32'd1;
            end
            if (w_trunc && (r_truncCnt != 16'hFFFF)) begin
                r_truncCnt <= r_truncCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Self-checking bench for rr_pkt_mux: behavioural round-robin arbiter,
// per-stream beat queues as the reference, directed plus random traffic.
module tb_rr_pkt_mux;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int MAXB = 4;
    localparam int SW   = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    inValid = '0;
    logic [N*DW-1:0] inData = '0;
    logic [N-1:0]    inLast = '0;
    logic [N-1:0]    inReady;
    logic [N-1:0]    reqBus;
    logic [N-1:0]    grantBus;
    logic            reqArb;
    logic            outValid;
    logic [DW-1:0]   outData;
    logic            outLast;
    logic [SW-1:0]   outSrc;
    logic            outReady = 1'b0;
    logic            truncErr;
`ifdef RR_PKT_MUX_STATS_EN
    logic [31:0]     pktCnt;
    logic [15:0]     truncCnt;
`endif

    rr_pkt_mux #(
        .NREQ          (N),
        .DATA_WIDTH    (DW),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inData   (inData),
        .inLast   (inLast),
        .inReady  (inReady),
        .reqBus   (reqBus),
        .grantBus (grantBus),
        .reqArb   (reqArb),
        .outValid (outValid),
        .outData  (outData),
        .outLast  (outLast),
        .outSrc   (outSrc),
        .outReady (outReady),
        .truncErr (truncErr)
`ifdef RR_PKT_MUX_STATS_EN
        ,
        .pktCnt   (pktCnt),
        .truncCnt (truncCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t gq[N][$];
    beat_t eq[N][$];
    int    in_len[N];
    int    seq[N];

    int n_vec = 0;
    int n_err = 0;

    int   valid_pct = 100;
    int   rdy_pct   = 100;
    int   base      = 0;
    logic force_en  = 1'b0;
    logic [N-1:0] force_val = '0;

    logic exp_arb = 1'b0;
    int   arb_src = 0;
    int   m_ends = 0, m_trunc = 0;
    int   n_arb = 0, o_trunc = 0;
    logic o_busy = 1'b0;
    int   o_src = 0, olen = 0;
    logic p_stall = 1'b0;
    logic [DW-1:0] p_data;
    logic p_last;
    logic [SW-1:0] p_src;
    int   rec[$];
    logic rec_en = 1'b0;

    function automatic logic [N-1:0] rr_grant(input logic [N-1:0] req,
                                              input int b);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (g == '0 && req[(b + k) % N]) g[(b + k) % N] = 1'b1;
        end
        return g;
    endfunction

    assign grantBus = force_en ? force_val : rr_grant(reqBus, base);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic gen_pkt(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = {4'(s), 12'(seq[s])};
            b.l = (k == len - 1);
            seq[s]++;
            gq[s].push_back(b);
            eq[s].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (gq[i].size() != 0 || eq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (gq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                inValid[i]        = 1'b1;
                inData[i*DW +: DW] = gq[i][0].d;
                inLast[i]         = gq[i][0].l;
            end else begin
                inValid[i]        = 1'b0;
                inData[i*DW +: DW] = DW'($urandom);
                inLast[i]         = 1'($urandom);
            end
        end
        outReady = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: drive, check at negedge, advance to posedge+1
    task automatic step();
        logic [N-1:0] acc;
        logic exp_tr, nxt_arb, elast;
        beat_t b;
        int s;
        drive();
        @(negedge clk);
        chk("reqBus", reqBus, inValid);
        chk("reqArb", reqArb, exp_arb);
        chk("inReady_1hot", ($countones(inReady) <= 1), 1);
        if (reqArb) begin
            chk("settle_rdy", inReady, 0);
            n_arb++;
            base = (arb_src + 1) % N;
        end
        acc = inValid & inReady;
        exp_tr = 1'b0;
        nxt_arb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                b = gq[i].pop_front();
                in_len[i]++;
                if (b.l || in_len[i] == MAXB) begin
                    nxt_arb = 1'b1;
                    arb_src = i;
                    m_ends++;
                    if (!b.l) exp_tr = 1'b1;
                    in_len[i] = 0;
                end
            end
        end
        chk("truncErr", truncErr, exp_tr);
        if (truncErr) o_trunc++;
        if (exp_tr) m_trunc++;
        if (p_stall) begin
            chk("hold_valid", outValid, 1);
            chk("hold_data", outData, p_data);
            chk("hold_last", outLast, p_last);
            chk("hold_src", outSrc, p_src);
        end
        if (outValid && outReady) begin
            s = int'(outSrc);
            if (s >= N || eq[s].size() == 0) begin
                chk("out_extra", 1, 0);
            end else begin
                b = eq[s].pop_front();
                olen++;
                if (o_busy) chk("out_lock", s, o_src);
                elast = b.l || (olen == MAXB);
                chk("outData", outData, b.d);
                chk("outLast", outLast, elast);
                if (rec_en) rec.push_back(s);
                o_busy = !elast;
                o_src  = s;
                if (elast) olen = 0;
            end
        end
        p_stall = outValid && !outReady;
        p_data  = outData;
        p_last  = outLast;
        p_src   = outSrc;
        exp_arb = nxt_arb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inValid = '0;
        #1;
        chk("rst_outValid", outValid, 0);
        chk("rst_outLast", outLast, 0);
        chk("rst_outData", outData, 0);
        chk("rst_outSrc", outSrc, 0);
        chk("rst_reqArb", reqArb, 0);
        chk("rst_truncErr", truncErr, 0);
        chk("rst_inReady", inReady, 0);
        for (int i = 0; i < N; i++) begin
            gq[i].delete();
            eq[i].delete();
            in_len[i] = 0;
        end
        base = 0;
        exp_arb = 1'b0;
        o_busy = 1'b0;
        olen = 0;
        p_stall = 1'b0;
        m_ends = 0;
        m_trunc = 0;
        n_arb = 0;
        o_trunc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        valid_pct = 100;
        rdy_pct = 100;
        for (int k = 0; k < 400; k++) begin
            if (all_empty()) break;
            step();
        end
        chk({tag, "_drain"}, all_empty(), 1);
        repeat (3) step();
    endtask

    initial begin
        int a0, t0, s;
        #3;
        do_reset();

        // Two streams, 3-beat packets: strict alternation
        gen_pkt(0, 3); gen_pkt(0, 3);
        gen_pkt(1, 3); gen_pkt(1, 3);
        rec.delete();
        rec_en = 1'b1;
        drain("alt");
        rec_en = 1'b0;
        chk("alt_len", rec.size(), 12);
        for (int k = 0; k < 12; k++) begin
            chk("alt_src", (k < rec.size()) ? rec[k] : 99, (k / 3) % 2);
        end
        chk("alt_arb", n_arb, 4);

        // Downstream stall of 5 cycles mid-packet
        a0 = n_arb;
        gen_pkt(0, 4);
        repeat (3) step();
        rdy_pct = 0;
        repeat (5) step();
        drain("stall");
        chk("stall_arb", n_arb - a0, 1);

        // 6-beat packet against a 4-beat limit
        a0 = n_arb;
        t0 = o_trunc;
        gen_pkt(2, 6);
        drain("trunc");
        chk("trunc_cnt", o_trunc - t0, 1);
        chk("trunc_arb", n_arb - a0, 2);

        // Grant moved to stream 1 while stream 0 is locked
        base = 0;
        gen_pkt(0, 4);
        gen_pkt(1, 2);
        rec.delete();
        rec_en = 1'b1;
        step();
        force_val = 3'b010;
        force_en = 1'b1;
        repeat (4) step();
        force_en = 1'b0;
        drain("force");
        rec_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("force_src", (k < rec.size()) ? rec[k] : 99, (k < 4) ? 0 : 1);
        end

        // Reset on the second beat of a 4-beat packet
        gen_pkt(0, 4);
        repeat (3) step();
        do_reset();
        repeat (3) step();
        gen_pkt(1, 3);
        drain("post_rst");
        chk("post_rst_arb", n_arb, 1);

        // Random traffic
        valid_pct = 70;
        rdy_pct = 70;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) < 25) begin
                s = $urandom_range(N - 1);
                if (gq[s].size() < 12) gen_pkt(s, $urandom_range(6, 1));
            end
            valid_pct = $urandom_range(100, 40);
            rdy_pct = $urandom_range(100, 30);
            step();
        end
        drain("rand");
        chk("rand_arb", n_arb, m_ends);
        chk("rand_trunc", o_trunc, m_trunc);
`ifdef RR_PKT_MUX_STATS_EN
        chk("pktCnt", pktCnt, m_ends);
        chk("truncCnt", truncCnt, m_trunc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
